// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types, status codes and helpers for the guessing game.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        HINT_NONE = 2'b00,
        HINT_LOW  = 2'b01,
        HINT_HIGH = 2'b10,
        HINT_OK   = 2'b11
    } hint_t;

    localparam logic [1:0] ST_PLAY = 2'b11;
    localparam logic [1:0] ST_WIN  = 2'b01;
    localparam logic [1:0] ST_LOSE = 2'b00;

    localparam int c_T_DIFF1 = 30;
    localparam int c_T_DIFF2 = 60;
    localparam int c_T_DIFF3 = 90;

    // Exclusive upper bound of a valid guess for a given digit count.
    function automatic logic [10:0] digit_limit(input logic [1:0] digits);
        case (digits)
            2'd1:    digit_limit = 11'd10;
            2'd2:    digit_limit = 11'd100;
            2'd3:    digit_limit = 11'd1000;
            default: digit_limit = 11'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_edge.sv
`default_nettype none
// ============================================================================
// Module      : button_edge
// Description : Registers a level input and flags its rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module button_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_d;

    // Delayed copy resets high so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst)
            r_level_d <= 1'b1;
        else
            r_level_d <= i_level;
    end

    assign o_rise = i_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/guess_tracker.sv
`default_nettype none
// ============================================================================
// Module      : guess_tracker
// Description : Evaluates guesses and keeps round/miss/timer counters per level.
// Revision    : 1.0 - initial release
// ============================================================================
module guess_tracker
    import game_pkg::*;
#(
    parameter int T_DIFF1 = c_T_DIFF1,
    parameter int T_DIFF2 = c_T_DIFF2,
    parameter int T_DIFF3 = c_T_DIFF3
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       confirmButton,
    input  logic       tick_1hz,
    input  logic [9:0] guess,
    input  logic [9:0] secret,
    input  logic [1:0] Max_digit,
    input  logic [1:0] WINorLOSE,
    output logic [2:0] incorrect_guesses,
    output logic [2:0] round,
    output logic [6:0] timer,
    output logic [1:0] hint,
    output logic       req_secret
);

    logic       w_press;
    logic       w_load;
    logic       w_play;
    logic       w_eval;
    logic       w_in_range;
    logic [6:0] w_preload;

    logic [2:0] r_incorrect;
    logic [2:0] r_round;
    logic [6:0] r_timer;
    hint_t      r_hint;
    logic       r_req;
    logic [1:0] r_prev_digit;

    button_edge u_confirm_edge (
        .clk     (clk),
        .rst     (restart),
        .i_level (confirmButton),
        .o_rise  (w_press)
    );

    always_comb begin
        w_preload = 7'(T_DIFF1);
        case (Max_digit)
            2'd2:    w_preload = 7'(T_DIFF2);
            2'd3:    w_preload = 7'(T_DIFF3);
            default: w_preload = 7'(T_DIFF1);
        endcase
    end

    assign w_load     = (Max_digit != 2'd0) && (Max_digit != r_prev_digit);
    assign w_play     = (WINorLOSE == ST_PLAY);
    assign w_eval     = w_press && w_play && (r_timer != 7'd0) && !w_load;
    assign w_in_range = ({1'b0, guess} < digit_limit(Max_digit));

    // A level load takes priority over both a press and a tick in the same cycle.
    always_ff @(posedge clk) begin
        if (restart) begin
            r_incorrect  <= 3'd0;
            r_round      <= 3'd1;
            r_timer      <= 7'(T_DIFF1);
            r_hint       <= HINT_NONE;
            r_req        <= 1'b0;
            r_prev_digit <= 2'd0;
        end else begin
            r_req <= 1'b0;
            if (w_load) begin
                r_round      <= 3'd1;
                r_incorrect  <= 3'd0;
                r_timer      <= w_preload;
                r_hint       <= HINT_NONE;
                r_req        <= 1'b1;
                r_prev_digit <= Max_digit;
            end else if (w_play) begin
                if (tick_1hz && (r_timer != 7'd0))
                    r_timer <= r_timer - 7'd1;
                if (w_eval) begin
                    if ((guess == secret) && w_in_range) begin
                        r_hint <= HINT_OK;
                        r_req  <= 1'b1;
                        if (r_round != 3'd7)
                            r_round <= r_round + 3'd1;
                    end else begin
                        r_hint <= (guess < secret) ? HINT_LOW : HINT_HIGH;
                        if (r_incorrect != 3'd7)
                            r_incorrect <= r_incorrect + 3'd1;
                    end
                end
            end
        end
    end

    assign incorrect_guesses = r_incorrect;
    assign round             = r_round;
    assign timer             = r_timer;
    assign hint              = r_hint;
    assign req_secret        = r_req;

endmodule
`default_nettype wire

// File: tb/tb_guess_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_guess_tracker
// Description : Directed self-checking bench for guess_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_tracker;

    logic       clk;
    logic       restart;
    logic       confirmButton;
    logic       tick_1hz;
    logic [9:0] guess;
    logic [9:0] secret;
    logic [1:0] Max_digit;
    logic [1:0] WINorLOSE;
    logic [2:0] incorrect_guesses;
    logic [2:0] round;
    logic [6:0] timer;
    logic [1:0] w_hint;
    logic       req_secret;

    int n_checks = 0;
    int n_pass   = 0;

    guess_tracker dut (
        .clk               (clk),
        .restart           (restart),
        .confirmButton     (confirmButton),
        .tick_1hz          (tick_1hz),
        .guess             (guess),
        .secret            (secret),
        .Max_digit         (Max_digit),
        .WINorLOSE         (WINorLOSE),
        .incorrect_guesses (incorrect_guesses),
        .round             (round),
        .timer             (timer),
        .hint              (w_hint),
        .req_secret        (req_secret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press with the given guess; outputs reflect the evaluation on return.
    task automatic press(input logic [9:0] g);
        guess         = g;
        confirmButton = 1'b1;
        step();
        confirmButton = 1'b0;
    endtask

    initial begin
        restart       = 1'b1;
        confirmButton = 1'b0;
        tick_1hz      = 1'b0;
        guess         = 10'd0;
        secret        = 10'd0;
        Max_digit     = 2'd1;
        WINorLOSE     = 2'b11;
        step();
        step();
        check("rst_timer", timer, 30);
        check("rst_round", round, 1);
        check("rst_incorrect", incorrect_guesses, 0);
        check("rst_hint", w_hint, 2'b00);
        check("rst_req", req_secret, 0);

        restart = 1'b0;
        step();
        check("load1_req", req_secret, 1);
        check("load1_timer", timer, 30);
        step();
        check("load1_req_low", req_secret, 0);

        // Correct guess, then hold the button
        secret        = 10'd7;
        guess         = 10'd7;
        confirmButton = 1'b1;
        step();
        check("ok_hint", w_hint, 2'b11);
        check("ok_round", round, 2);
        check("ok_req", req_secret, 1);
        repeat (20) step();
        check("hold_round", round, 2);
        check("hold_req", req_secret, 0);
        confirmButton = 1'b0;
        step();

        // Level 1 guess equal to secret but out of range
        secret = 10'd12;
        press(10'd12);
        check("range_hint", w_hint, 2'b10);
        check("range_incorrect", incorrect_guesses, 1);
        check("range_round", round, 2);
        step();
        secret = 10'd9;
        press(10'd3);
        check("low1_hint", w_hint, 2'b01);
        check("low1_incorrect", incorrect_guesses, 2);
        step();
        press(10'd9);
        check("edge9_hint", w_hint, 2'b11);
        check("edge9_round", round, 3);
        step();
        secret = 10'd0;
        press(10'd0);
        check("zero_round", round, 4);
        step();

        // Level change 1 -> 2
        Max_digit = 2'd2;
        step();
        check("lvl2_round", round, 1);
        check("lvl2_incorrect", incorrect_guesses, 0);
        check("lvl2_timer", timer, 60);
        check("lvl2_req", req_secret, 1);
        check("lvl2_hint", w_hint, 2'b00);
        step();

        // Level change 2 -> 3 coincident with a correct press: press dropped
        Max_digit = 2'd3;
        secret    = 10'd5;
        press(10'd5);
        check("lvl3_round", round, 1);
        check("lvl3_hint", w_hint, 2'b00);
        check("lvl3_timer", timer, 90);
        step();

        secret = 10'd500;
        press(10'd200);
        check("low3_hint", w_hint, 2'b01);
        check("low3_incorrect", incorrect_guesses, 1);
        step();
        press(10'd900);
        check("high3_hint", w_hint, 2'b10);
        check("high3_incorrect", incorrect_guesses, 2);
        step();
        secret = 10'd999;
        press(10'd999);
        check("ok999_hint", w_hint, 2'b11);
        check("ok999_round", round, 2);
        step();
        for (int i = 0; i < 6; i++) begin
            press(10'd1);
            step();
        end
        check("sat_incorrect", incorrect_guesses, 7);

        // Timer countdown to 1, then press and tick together
        tick_1hz = 1'b1;
        repeat (89) step();
        tick_1hz = 1'b0;
        check("timer_one", timer, 1);
        secret        = 10'd123;
        guess         = 10'd123;
        confirmButton = 1'b1;
        tick_1hz      = 1'b1;
        step();
        confirmButton = 1'b0;
        tick_1hz      = 1'b0;
        check("pt_timer", timer, 0);
        check("pt_hint", w_hint, 2'b11);
        check("pt_round", round, 3);
        step();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("timer_sat0", timer, 0);
        press(10'd1);
        check("t0_hint", w_hint, 2'b11);
        check("t0_round", round, 3);
        step();

        // Restart mid-game, then reload level 1
        restart = 1'b1;
        Max_digit = 2'd1;
        step();
        restart = 1'b0;
        check("rst2_timer", timer, 30);
        check("rst2_round", round, 1);
        check("rst2_incorrect", incorrect_guesses, 0);
        check("rst2_req", req_secret, 0);
        step();
        check("rst2_load_req", req_secret, 1);
        step();

        // Game end: everything freezes, no load
        WINorLOSE = 2'b00;
        Max_digit = 2'd0;
        tick_1hz  = 1'b1;
        repeat (5) step();
        tick_1hz = 1'b0;
        check("end_timer", timer, 30);
        check("end_req", req_secret, 0);
        secret = 10'd50;
        press(10'd1);
        check("end_hint", w_hint, 2'b00);
        check("end_incorrect", incorrect_guesses, 0);
        step();

        restart = 1'b1;
        step();
        restart   = 1'b0;
        Max_digit = 2'd1;
        WINorLOSE = 2'b11;
        step();
        check("final_load_req", req_secret, 1);
        check("final_timer", timer, 30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
